fft_bf_scheduler: RTL
=====================

# fft_bf_scheduler

Sequencing controller for the in-place radix-2 DIT FFT butterfly datapath. On a start pulse it walks all log2(N) stages, issuing one butterfly per cycle. For each butterfly it drives both operand read addresses and the twiddle index. After a fixed pipeline latency it drives the matching write-back addresses. Inputs are expected in bit-reversed order in the data memory; outputs land in natural order.

## Interface
- N, 8: FFT length, power of two, N >= 4
- LOG2N, $clog2(N): stage count; derived, not overridden
- BF_LAT, 2: cycles from rd_en to the matching wr_en (memory read + butterfly + output register), BF_LAT >= 1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- stall  in  1  freezes issue (memory port busy); does not freeze the write-back pipeline
- rd_en  out  1  butterfly issued this cycle
- rd_addr_a / rd_addr_b  out  LOG2N  upper/lower operand addresses
- tw_idx  out  LOG2N-1  twiddle ROM index, aligned with rd_en
- wr_en  out  1  write-back of both butterfly outputs
- wr_addr_a / wr_addr_b  out  LOG2N  write addresses (out[0]→a, out[1]→b)
- busy  out  1  transform in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Counters: stage s in 0..LOG2N-1 and butterfly b in 0..N/2-1. Both are zero on entry to ISSUE.
- Address rule, per stage:
  - half = 1<<s, pos = b & (half-1), grp = b >> s
  - rd_addr_a = (grp << (s+1)) + pos
  - rd_addr_b = rd_addr_a + half
  - tw_idx = pos << (LOG2N-1-s)
- IDLE: start=1 → ISSUE. start is ignored in every other state.
- ISSUE: rd_en=1 every cycle where stall=0, and b increments. On the issue with b = N/2-1 → DRAIN.
- ISSUE, stall=1: rd_en=0; address and tw_idx outputs hold their value.
- DRAIN: stays until the last write of the current stage has asserted wr_en. Then:
  - if s < LOG2N-1: s++, b=0 → ISSUE
  - otherwise → DONE
- DRAIN ignores stall.
- DONE: done=1 for exactly one cycle → IDLE.
- Write-back path:
  - BF_LAT-deep shift register of {valid, addr_a, addr_b}, advancing every cycle.
  - wr_en and wr_addr_* equal the rd_en and rd_addr_* values from BF_LAT cycles earlier.
- No read-after-write hazard can occur: a stage's reads never begin before all writes of the previous stage have retired.
- busy = 1 in ISSUE and DRAIN, 0 in IDLE and DONE.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, shift register cleared.
- Reset mid-transform: no wr_en is produced after reset, and no done pulse.
- start sampled at edge of cycle 0 → first rd_en in cycle 1.
- Write latency: wr_en exactly BF_LAT cycles after its rd_en.
- Stage gap: the first issue of stage s+1 occurs in the cycle after the last wr_en of stage s.
- Unstalled duration:
  - each stage takes N/2 + BF_LAT cycles
  - done is asserted in cycle LOG2N·(N/2+BF_LAT)+1
- stall asserted in the cycle of the last issue of a stage: the issue is deferred, and so is the DRAIN entry.
- start coincident with rst: rst wins.
- start during DONE: ignored.

## Structure
- Shared package fft_pkg holds:
  - the fixed_point struct (23-bit real_bits / imaginary_bits)
  - the Q15 fraction shift constant (15)
  - the state enum fft_sched_state_t
- The scheduler only carries addresses. Data widths are referenced solely for twiddle ROM sizing (N/2 entries).
- Sub-module fft_bf_addr_gen: combinational (s, b) → (addr_a, addr_b, tw_idx). It is reused by the twiddle ROM address checker in the bench.
- The write-back delay line is inline; no sub-module.

## Test plan
- N=8, BF_LAT=2, start at cycle 0, stall=0. Reads, as (addr_a, addr_b, tw):
  - cycles 1–4: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - cycles 7–10: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - cycles 13–16: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- Same run: wr_en in cycles 3–6, 9–12 and 15–18 with the addresses above; done=1 in cycle 19 only; busy=1 in cycles 1–18.
- stall=1 in cycles 2–3 of the same run:
  - rd_en low in those cycles and rd_addr holds (2,3)
  - every subsequent event shifts by 2 cycles; done lands in cycle 21
- start pulsed again in cycles 5 and 19 (during DRAIN and during DONE): ignored, with no second transform.
- rst asserted in cycle 10: all outputs 0 from cycle 11; no wr_en or done follows; a new start in cycle 12 gives first rd_en in cycle 13 at (0,1,0).
- N=16, BF_LAT=5, random stall with 30% density: a scoreboard checks that every address pair is covered exactly once per stage, that wr_en lags rd_en by exactly 5 cycles, and that no stage-s+1 read precedes any stage-s write.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 DIT FFT datapath and its scheduler:
//   - fixed_point       : complex sample, 23-bit real / imaginary parts
//   - Q15_SHIFT         : fraction shift applied after Q15 twiddle multiplies
//   - fft_sched_state_t : butterfly scheduler FSM states
//   - tw_rom_depth()    : twiddle ROM entry count for an N-point transform
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int unsigned FIXED_W   = 23;
  localparam int unsigned Q15_SHIFT = 15;

  typedef struct packed {
    logic signed [FIXED_W-1:0] real_bits;
    logic signed [FIXED_W-1:0] imaginary_bits;
  } fixed_point;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_sched_state_t;

  // A radix-2 transform only ever needs the first half of the unit circle.
  function automatic int unsigned tw_rom_depth(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_bf_addr_gen
// Combinational butterfly address generator for an in-place radix-2 DIT FFT.
// Ports:
//   s_i        stage index, 0..LOG2N-1
//   b_i        butterfly index within the stage, 0..N/2-1
//   addr_a_o   upper operand address
//   addr_b_o   lower operand address (addr_a_o + 2^s)
//   tw_idx_o   twiddle ROM index
// -----------------------------------------------------------------------------
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned LOG2N = $clog2(N),
  localparam int unsigned SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1,
  localparam int unsigned TW_W  = $clog2(tw_rom_depth(N))
) (
  input  logic [SW-1:0]    s_i,
  input  logic [LOG2N-2:0] b_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [TW_W-1:0]  tw_idx_o
);

  localparam logic [LOG2N-1:0] ONE = LOG2N'(1);

  logic [LOG2N-1:0] b_ext_s;
  logic [LOG2N-1:0] half_s;
  logic [LOG2N-1:0] pos_s;
  logic [LOG2N-1:0] grp_s;
  logic [LOG2N-1:0] base_s;

  // Split b into group/position and map onto the in-place memory layout.
  always_comb begin
    b_ext_s  = {1'b0, b_i};
    half_s   = ONE << s_i;
    pos_s    = b_ext_s & (half_s - ONE);
    grp_s    = b_ext_s >> s_i;
    // Two shifts instead of << (s+1) so the shift amount never wraps in SW bits.
    base_s   = (grp_s << s_i) << 1'b1;
    addr_a_o = base_s + pos_s;
    addr_b_o = base_s + pos_s + half_s;
    // pos < 2^s, so the shifted value always fits in TW_W bits.
    tw_idx_o = TW_W'(pos_s << (TW_W - s_i));
  end

endmodule

// File: rtl/fft_bf_scheduler.sv
// -----------------------------------------------------------------------------
// fft_bf_scheduler
// Sequencer for an in-place radix-2 DIT FFT butterfly datapath. Walks all
// stages, issuing one butterfly per unstalled cycle, then replays each issue's
// addresses BF_LAT cycles later as the write-back.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle request, honoured only when idle
//   stall_i                 holds issue (read port busy); write-back keeps moving
//   rd_en_o                 butterfly issued this cycle
//   rd_addr_a_o/_b_o        operand read addresses
//   tw_idx_o                twiddle ROM index aligned with rd_en_o
//   wr_en_o                 write-back of both butterfly outputs
//   wr_addr_a_o/_b_o        write-back addresses
//   busy_o                  transform in progress
//   done_o                  one-cycle completion pulse
// -----------------------------------------------------------------------------
module fft_bf_scheduler
  import fft_pkg::*;
#(
  parameter  int unsigned N      = 8,
  parameter  int unsigned BF_LAT = 2,
  localparam int unsigned LOG2N  = $clog2(N),
  localparam int unsigned SW     = (LOG2N > 1) ? $clog2(LOG2N) : 1,
  localparam int unsigned TW_W   = $clog2(tw_rom_depth(N))
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [TW_W-1:0]  tw_idx_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] B_LAST = (LOG2N-1)'(N / 2 - 1);

  fft_sched_state_t state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [LOG2N-2:0] b_q, b_d;

  logic [LOG2N-1:0] gen_a_s, gen_b_s;
  logic [TW_W-1:0]  gen_tw_s;
  logic [LOG2N-1:0] rd_a_q, rd_b_q;
  logic [TW_W-1:0]  tw_q;
  logic             busy_q, done_q;

  logic             pv_q [BF_LAT];
  logic [LOG2N-1:0] pa_q [BF_LAT];
  logic [LOG2N-1:0] pb_q [BF_LAT];
  logic             pending_s;
  logic             last_wr_s;

  // Addresses are computed for the next (s, b) so they can be registered.
  fft_bf_addr_gen #(.N(N)) u_addr_gen (
    .s_i      (s_d),
    .b_i      (b_d),
    .addr_a_o (gen_a_s),
    .addr_b_o (gen_b_s),
    .tw_idx_o (gen_tw_s)
  );

  // Stall gates issue within the same cycle; addresses simply hold.
  assign rd_en_o     = (state_q == ST_ISSUE) && !stall_i;
  assign rd_addr_a_o = rd_a_q;
  assign rd_addr_b_o = rd_b_q;
  assign tw_idx_o    = tw_q;
  assign wr_en_o     = pv_q[BF_LAT-1];
  assign wr_addr_a_o = pa_q[BF_LAT-1];
  assign wr_addr_b_o = pb_q[BF_LAT-1];
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // Any write still in flight behind the output stage of the delay line.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < int'(BF_LAT) - 1; i++) begin
      pending_s = pending_s | pv_q[i];
    end
    last_wr_s = wr_en_o && !pending_s;
  end

  // Next-state and counter logic for the issue/drain sequencer.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          s_d     = '0;
          b_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (stall_i) begin
          state_d = ST_ISSUE;
        end else if (b_q == B_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Next stage may only read once every write of this stage has retired.
        if (!last_wr_s) begin
          state_d = ST_DRAIN;
        end else if (s_q == S_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
          s_d     = s_q + 1'b1;
          b_d     = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
        b_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        b_d     = '0;
      end
    endcase
  end

  // FSM state, counters and registered issue-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      if (state_d == ST_ISSUE) begin
        rd_a_q <= gen_a_s;
        rd_b_q <= gen_b_s;
        tw_q   <= gen_tw_s;
      end else begin
        rd_a_q <= '0;
        rd_b_q <= '0;
        tw_q   <= '0;
      end
      busy_q <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      done_q <= (state_d == ST_DONE);
    end
  end

  // Write-back delay line; always advances, reset drops in-flight writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(BF_LAT); i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_en_o;
      pa_q[0] <= rd_en_o ? rd_addr_a_o : '0;
      pb_q[0] <= rd_en_o ? rd_addr_b_o : '0;
      for (int i = 1; i < int'(BF_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
    end
  end

endmodule
